// File: rtl/audiosystem_ram_dp_pipe_pkg.sv
// Shared types and helpers for the dual-port audio sample RAM.
package audiosystem_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_t;

  localparam int unsigned MAX_READ_LATENCY = 2;
  localparam int unsigned MAX_DATA_W       = 256;
  localparam int unsigned MAX_BE_W         = MAX_DATA_W / 8;

  // Overlay the enabled byte lanes of new_word onto old_word.
  // Callers zero-extend to MAX_DATA_W and truncate the result back to their width.
  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] r;
    r = old_word;
    for (int b = 0; b < int'(MAX_BE_W); b++) begin
      if (be[b]) r[8*b +: 8] = new_word[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/audiosystem_ram_dp_pipe_if.sv
// Avalon-MM slave port bundle for one RAM port.
interface audiosystem_ram_dp_pipe_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 13
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/audiosystem_ram_dp_pipe_rd_pipe.sv
// Read-return pipeline: READ_LATENCY-deep valid/data shift register, flushed by reset.
module audiosystem_ram_rd_pipe
  import audiosystem_ram_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);
  // Out-of-range latencies are clamped to the legal 1..MAX_READ_LATENCY window.
  localparam int unsigned LAT = (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                                (READ_LATENCY < 1) ? 1 : READ_LATENCY;

  logic [LAT-1:0]    vld_q;
  logic [DATA_W-1:0] dat_q [LAT];

  // Shift valid and data one stage per cycle; data only loads with a valid beat.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < int'(LAT); i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) dat_q[0] <= in_data;
      for (int i = 1; i < int'(LAT); i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign out_data  = dat_q[LAT-1];

endmodule

// File: rtl/audiosystem_ram_dp_pipe.sv
// True-dual-port audio sample RAM with pipelined reads, same-cycle forwarding,
// byte-lane write arbitration (s1 wins) and an optional zero-fill sweep after reset.
// Optional feature macro: AUDIOSYSTEM_RAM_COLLISION_CNT_EN adds collision_count.
module audiosystem_ram_dp_pipe
  import audiosystem_ram_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 13,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  audiosystem_ram_dp_pipe_if.slave s1,
  audiosystem_ram_dp_pipe_if.slave s2,
  output logic                     init_done
`ifdef AUDIOSYSTEM_RAM_COLLISION_CNT_EN
  ,
  output logic [15:0]              collision_count
`endif
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned BE_W  = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  ram_state_t        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              wait_q, wait_d;
  logic              init_d;

  logic              wr1, wr2, rd1, rd2, same_wr;
  logic [DATA_W-1:0] rd_word1, rd_word2;

  // Request acceptance; a read paired with a write on the same port is dropped.
  assign wr1     = s1.write && !wait_q;
  assign wr2     = s2.write && !wait_q;
  assign rd1     = s1.read && !s1.write && !wait_q;
  assign rd2     = s2.read && !s2.write && !wait_q;
  assign same_wr = wr1 && wr2 && (s1.address == s2.address);

  // State, clear pointer and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_ptr_q <= '0;
      wait_q    <= (CLEAR_ON_RESET != 0);
      init_done <= (CLEAR_ON_RESET == 0);
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      wait_q    <= wait_d;
      init_done <= init_d;
    end
  end

  // Next-state logic: sweep every address once, then serve both ports.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    wait_d    = 1'b0;
    init_d    = 1'b1;
    case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        wait_d    = 1'b1;
        init_d    = 1'b0;
        if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d   = READY;
          clr_ptr_d = '0;
          wait_d    = 1'b0;
          init_d    = 1'b1;
        end
      end
      READY:   state_d = READY;
      default: state_d = READY;
    endcase
  end

  // Memory update: clear sweep, or per-lane writes with s1 owning contested lanes.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (state_q == CLEAR) begin
        mem[clr_ptr_q] <= '0;
      end else begin
        for (int b = 0; b < int'(BE_W); b++) begin
          if (wr2 && s2.byteenable[b] && !(same_wr && s1.byteenable[b]))
            mem[s2.address][8*b +: 8] <= s2.writedata[8*b +: 8];
          if (wr1 && s1.byteenable[b])
            mem[s1.address][8*b +: 8] <= s1.writedata[8*b +: 8];
        end
      end
    end
  end

  // Read-during-write forwarding: a reader sees the other port's same-cycle write.
  always_comb begin
    rd_word1 = mem[s1.address];
    if (wr2 && (s2.address == s1.address))
      rd_word1 = DATA_W'(byte_merge(MAX_DATA_W'(rd_word1), MAX_DATA_W'(s2.writedata),
                                    MAX_BE_W'(s2.byteenable)));
    rd_word2 = mem[s2.address];
    if (wr1 && (s1.address == s2.address))
      rd_word2 = DATA_W'(byte_merge(MAX_DATA_W'(rd_word2), MAX_DATA_W'(s1.writedata),
                                    MAX_BE_W'(s1.byteenable)));
  end

  assign s1.waitrequest = wait_q;
  assign s2.waitrequest = wait_q;

  audiosystem_ram_rd_pipe #(.DATA_W(DATA_W), .READ_LATENCY(READ_LATENCY)) u_rd_pipe_s1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (rd1),
    .in_data   (rd_word1),
    .out_valid (s1.readdatavalid),
    .out_data  (s1.readdata)
  );

  audiosystem_ram_rd_pipe #(.DATA_W(DATA_W), .READ_LATENCY(READ_LATENCY)) u_rd_pipe_s2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (rd2),
    .in_data   (rd_word2),
    .out_valid (s2.readdatavalid),
    .out_data  (s2.readdata)
  );

`ifdef AUDIOSYSTEM_RAM_COLLISION_CNT_EN
  // Saturating count of cycles in which both ports write the same word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      collision_count <= '0;
    end else if (same_wr && (collision_count != 16'hFFFF)) begin
      collision_count <= collision_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_audiosystem_ram_dp_pipe.sv
// Scoreboard bench: dut1 (latency 1, clear sweep) and dut2 (latency 2, no sweep).
module tb_audiosystem_ram_dp_pipe;

  logic clk;
  logic reset_n;
  logic init_done1, init_done2;
  int   cyc;
  int   n_vec;
  int   n_err;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q_p1[$];
  exp_t q_p2[$];
  exp_t q_q1[$];
  exp_t q_q2[$];

  audiosystem_ram_dp_pipe_if #(.DATA_W(32), .ADDR_W(13)) p1 ();
  audiosystem_ram_dp_pipe_if #(.DATA_W(32), .ADDR_W(13)) p2 ();
  audiosystem_ram_dp_pipe_if #(.DATA_W(32), .ADDR_W(13)) q1 ();
  audiosystem_ram_dp_pipe_if #(.DATA_W(32), .ADDR_W(13)) q2 ();

`ifdef AUDIOSYSTEM_RAM_COLLISION_CNT_EN
  logic [15:0] coll1, coll2;
`endif

  audiosystem_ram_dp_pipe #(.DATA_W(32), .ADDR_W(13), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_dut1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .s1        (p1.slave),
    .s2        (p2.slave),
    .init_done (init_done1)
`ifdef AUDIOSYSTEM_RAM_COLLISION_CNT_EN
    ,
    .collision_count (coll1)
`endif
  );

  audiosystem_ram_dp_pipe #(.DATA_W(32), .ADDR_W(13), .READ_LATENCY(2), .CLEAR_ON_RESET(0)) u_dut2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .s1        (q1.slave),
    .s2        (q2.slave),
    .init_done (init_done2)
`ifdef AUDIOSYSTEM_RAM_COLLISION_CNT_EN
    ,
    .collision_count (coll2)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int p, input logic [31:0] d, input int due);
    exp_t e;
    e.data = d;
    e.due  = due;
    case (p)
      1: q_p1.push_back(e);
      2: q_p2.push_back(e);
      3: q_q1.push_back(e);
      default: q_q2.push_back(e);
    endcase
  endtask

  // Pop and compare one returned read beat for port p.
  task automatic mon(input int p, input logic v, input logic [31:0] d);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (v) begin
      case (p)
        1: if (q_p1.size() > 0) begin e = q_p1.pop_front(); have = 1'b1; end
        2: if (q_p2.size() > 0) begin e = q_p2.pop_front(); have = 1'b1; end
        3: if (q_q1.size() > 0) begin e = q_q1.pop_front(); have = 1'b1; end
        default: if (q_q2.size() > 0) begin e = q_q2.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid port%0d: got pulse with data %h, required no pulse", p, d);
      end else begin
        check($sformatf("rd_data_port%0d", p), d, e.data);
        check($sformatf("rd_latency_port%0d", p), 32'(cyc), 32'(e.due));
      end
    end
  endtask

  task automatic idle_all();
    p1.read = 0; p1.write = 0; p1.address = '0; p1.byteenable = '0; p1.writedata = '0;
    p2.read = 0; p2.write = 0; p2.address = '0; p2.byteenable = '0; p2.writedata = '0;
    q1.read = 0; q1.write = 0; q1.address = '0; q1.byteenable = '0; q1.writedata = '0;
    q2.read = 0; q2.write = 0; q2.address = '0; q2.byteenable = '0; q2.writedata = '0;
  endtask

  // Drive one request for the coming edge; reads queue their expected beat.
  task automatic req(input int p, input logic rd, input logic wr, input logic [12:0] a,
                     input logic [3:0] be, input logic [31:0] wd, input logic [31:0] ex);
    case (p)
      1: begin p1.read = rd; p1.write = wr; p1.address = a; p1.byteenable = be; p1.writedata = wd; end
      2: begin p2.read = rd; p2.write = wr; p2.address = a; p2.byteenable = be; p2.writedata = wd; end
      3: begin q1.read = rd; q1.write = wr; q1.address = a; q1.byteenable = be; q1.writedata = wd; end
      default: begin q2.read = rd; q2.write = wr; q2.address = a; q2.byteenable = be; q2.writedata = wd; end
    endcase
    if (rd && !wr) push(p, ex, cyc + ((p <= 2) ? 1 : 2));
  endtask

  task automatic tick();
    @(negedge clk);
    idle_all();
  endtask

  initial begin
    int cnt;
    clk     = 1'b0;
    cyc     = 0;
    n_vec   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    idle_all();

    fork
      forever begin
        @(negedge clk);
        mon(1, p1.readdatavalid, p1.readdata);
        mon(2, p2.readdatavalid, p2.readdata);
        mon(3, q1.readdatavalid, q1.readdata);
        mon(4, q2.readdatavalid, q2.readdata);
      end
      begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
      end
    join_none

    // Reset values for both configurations.
    repeat (3) @(negedge clk);
    check("rst_wait_dut1", 32'(p1.waitrequest), 32'd1);
    check("rst_init_dut1", 32'(init_done1), 32'd0);
    check("rst_rdv_dut1", 32'(p2.readdatavalid), 32'd0);
    check("rst_rdata_dut1", p1.readdata, 32'h0);
    check("rst_wait_dut2", 32'(q1.waitrequest), 32'd0);
    check("rst_init_dut2", 32'(init_done2), 32'd1);
    check("rst_rdata_dut2", q2.readdata, 32'h0);

    // Clear sweep length.
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 9000 && p1.waitrequest; i++) begin
      cnt++;
      @(negedge clk);
    end
    check("sweep_cycles", 32'(cnt), 32'd8192);
    check("init_after_sweep", 32'(init_done1), 32'd1);

    // Cleared contents read back as zero.
    req(2, 1, 0, 13'h0ABC, 4'h0, 32'h0, 32'h0);
    req(1, 1, 0, 13'h0000, 4'h0, 32'h0, 32'h0);
    tick();

    // Partial write with same-cycle cross-port read.
    req(1, 0, 1, 13'h010, 4'b1111, 32'h11223344, 32'h0);
    tick();
    req(1, 0, 1, 13'h010, 4'b0011, 32'hDEADBEEF, 32'h0);
    req(2, 1, 0, 13'h010, 4'h0, 32'h0, 32'h1122BEEF);
    tick();
    req(2, 1, 0, 13'h010, 4'h0, 32'h0, 32'h1122BEEF);
    tick();

    // Both ports write the top word; s1 owns its enabled lanes.
    req(1, 0, 1, 13'h1FFF, 4'b0101, 32'hAAAAAAAA, 32'h0);
    req(2, 0, 1, 13'h1FFF, 4'b1111, 32'h55555555, 32'h0);
    tick();
`ifdef AUDIOSYSTEM_RAM_COLLISION_CNT_EN
    check("collision_count_1", 32'(coll1), 32'd1);
`endif
    req(1, 1, 0, 13'h1FFF, 4'h0, 32'h0, 32'h55AA55AA);
    tick();

    // Mixed-port read-during-write, full and partial lanes.
    req(1, 0, 1, 13'h020, 4'b1111, 32'hCAFEF00D, 32'h0);
    req(2, 1, 0, 13'h020, 4'h0, 32'h0, 32'hCAFEF00D);
    tick();
    req(2, 0, 1, 13'h020, 4'b0001, 32'h000000FF, 32'h0);
    req(1, 1, 0, 13'h020, 4'h0, 32'h0, 32'hCAFEF0FF);
    tick();

    // Same-port read+write: write wins, no read beat.
    req(1, 1, 1, 13'h030, 4'b1111, 32'h12345678, 32'h0);
    tick();
    req(1, 1, 0, 13'h030, 4'h0, 32'h0, 32'h12345678);
    tick();

    // Back-to-back reads, in order.
    req(2, 1, 0, 13'h010, 4'h0, 32'h0, 32'h1122BEEF);
    tick();
    req(2, 1, 0, 13'h1FFF, 4'h0, 32'h0, 32'h55AA55AA);
    tick();
    req(2, 1, 0, 13'h020, 4'h0, 32'h0, 32'hCAFEF0FF);
    tick();

    // Latency-2 instance: fill then pipelined reads 0..3.
    for (int i = 0; i < 4; i++) begin
      req(3, 0, 1, 13'(i), 4'b1111, 32'h100 + 32'(i), 32'h0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      req(3, 1, 0, 13'(i), 4'h0, 32'h0, 32'h100 + 32'(i));
      tick();
    end
    req(3, 0, 1, 13'h007, 4'b1111, 32'h00000005, 32'h0);
    req(4, 1, 0, 13'h007, 4'h0, 32'h0, 32'h00000005);
    tick();
    repeat (4) tick();

    // Reset mid-sweep restarts the sweep; a stalled write lands once serviced.
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
`ifdef AUDIOSYSTEM_RAM_COLLISION_CNT_EN
    check("collision_count_rst", 32'(coll1), 32'd0);
`endif
    p1.write = 1; p1.address = 13'h040; p1.byteenable = 4'b1111; p1.writedata = 32'h0F0F0F0F;
    cnt = 0;
    for (int i = 0; i < 9000 && !init_done1; i++) begin
      cnt++;
      @(negedge clk);
    end
    check("restart_sweep_cycles", 32'(cnt), 32'd8192);
    tick();
    req(1, 1, 0, 13'h040, 4'h0, 32'h0, 32'h0F0F0F0F);
    req(2, 1, 0, 13'h010, 4'h0, 32'h0, 32'h0);
    tick();
    repeat (4) tick();

    check("sb_drain_p1", 32'(q_p1.size()), 32'd0);
    check("sb_drain_p2", 32'(q_p2.size()), 32'd0);
    check("sb_drain_q1", 32'(q_q1.size()), 32'd0);
    check("sb_drain_q2", 32'(q_q2.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
